// File: rtl/dsp_dma_pkg.sv
// Shared constants for the DMA sample packing path: output word layout
// and the packer state encoding.
package dsp_dma_pkg;

  localparam int OUT_WIDTH = 32;
  localparam int LANE_OFS  = 16;

  // Packer states: fill lane 0, fill lane 1, present word
  localparam logic [1:0] ST_LO  = 2'd0;
  localparam logic [1:0] ST_HI  = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty and occupancy output.
// Read data is the head entry, visible the cycle after it is written.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  // Full blocks writes even when a pop happens in the same cycle
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dma_stream_packer.sv
// Packs DMA samples two per 32-bit word with block-end tagging, sticky
// overflow / short-block flags, and a valid/ready output handshake.
module dma_stream_packer
  import dsp_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int BLOCK_SIZE = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  input  logic                          in_done,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  input  logic                          clear_err,
  output logic                          overflow,
  output logic                          len_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_SIZE - 1);

  logic [CW-1:0]         wr_cnt, cnt_nxt;
  logic                  last_tag, accept, drop, short_blk;
  logic                  f_full, f_empty, pop;
  logic [DATA_WIDTH:0]   f_rd;
  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] lane0, lane1;

  assign last_tag  = (wr_cnt == LAST_IDX);
  assign accept    = in_valid & ~f_full;
  assign drop      = in_valid & f_full;
  assign short_blk = in_done & (cnt_nxt != '0);

  // Block index after this cycle's write, before any in_done override
  always_comb begin
    cnt_nxt = wr_cnt;
    if (accept) cnt_nxt = last_tag ? '0 : wr_cnt + 1'b1;
  end

  // Block sample counter; a short in_done restarts the block
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_cnt <= '0;
    else          wr_cnt <= short_blk ? '0 : cnt_nxt;
  end

  // Sticky flags, a set in the same cycle beats clear_err
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      overflow <= drop      | (overflow & ~clear_err);
      len_err  <= short_blk | (len_err  & ~clear_err);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (in_valid),
    .wr_data ({last_tag, in_data}),
    .rd_en   (pop),
    .rd_data (f_rd),
    .full    (f_full),
    .empty   (f_empty),
    .level   (fifo_level)
  );

  // Never pop while a finished word is waiting for the consumer
  assign pop = (state != ST_OUT) & ~f_empty;

  // Packer FSM: LO fills lane 0, HI fills lane 1, OUT waits for ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_LO;
      lane0    <= '0;
      lane1    <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        ST_LO: if (!f_empty) begin
          lane0 <= f_rd[DATA_WIDTH-1:0];
          if (f_rd[DATA_WIDTH]) begin
            // block ended on an odd sample: pad lane 1
            lane1    <= '0;
            out_last <= 1'b1;
            state    <= ST_OUT;
          end else begin
            state <= ST_HI;
          end
        end
        ST_HI: if (!f_empty) begin
          lane1    <= f_rd[DATA_WIDTH-1:0];
          out_last <= f_rd[DATA_WIDTH];
          state    <= ST_OUT;
        end
        ST_OUT: if (out_ready) state <= ST_LO;
        default: state <= ST_LO;
      endcase
    end
  end

  assign out_valid = (state == ST_OUT);

  // Lane placement into the output word, unused bits zero
  always_comb begin
    out_data = '0;
    out_data[DATA_WIDTH-1:0]          = lane0;
    out_data[LANE_OFS+:DATA_WIDTH]    = lane1;
  end

endmodule

// File: tb/tb_dma_stream_packer.sv
// Bench for dma_stream_packer: queue-based reference model compared every
// cycle, directed scenarios pinned with literal words, and random traffic.
module tb_dma_stream_packer;

  localparam int DW    = 12;
  localparam int BS    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic          in_valid, in_done, out_ready, clear_err;
  logic [31:0]   out_data;
  logic          out_valid, out_last, overflow, len_err;
  logic [4:0]    fifo_level;

  logic          in_valid7;
  logic [31:0]   out_data7;
  logic          out_valid7, out_last7, overflow7, len_err7;
  logic [4:0]    fifo_level7;

  always #5 clk = ~clk;

  dma_stream_packer #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_done(in_done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .clear_err(clear_err),
    .overflow(overflow), .len_err(len_err), .fifo_level(fifo_level)
  );

  dma_stream_packer #(.DATA_WIDTH(DW), .BLOCK_SIZE(7), .FIFO_DEPTH(DEPTH)) dut7 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid7),
    .in_done(1'b0), .out_data(out_data7), .out_valid(out_valid7),
    .out_ready(1'b1), .out_last(out_last7), .clear_err(1'b0),
    .overflow(overflow7), .len_err(len_err7), .fifo_level(fifo_level7)
  );

  typedef struct {logic tag; logic [15:0] d;} ent_t;

  ent_t        q[$];
  int          m_wr, m_n;
  bit          m_hold, m_last, m_ovf, m_len;
  logic [15:0] m_l0, m_l1;
  logic [32:0] log_q[$];
  logic [32:0] q7[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wr = 0; m_n = 0; m_hold = 0; m_last = 0;
    m_ovf = 0; m_len = 0; m_l0 = '0; m_l1 = '0;
  endtask

  // Advance the model across one rising edge using current inputs
  task automatic step_model();
    bit full, os, ls;
    ent_t e;
    if (!reset_n) begin model_reset(); return; end
    full = (q.size() == DEPTH);
    if (m_hold) begin
      if (out_ready) begin
        log_q.push_back({m_last, m_l1, m_l0});
        m_hold = 0; m_n = 0;
      end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (m_n == 0) begin
        m_l0 = e.d; m_n = 1;
        if (e.tag) begin m_l1 = '0; m_last = 1; m_hold = 1; end
      end else begin
        m_l1 = e.d; m_last = e.tag; m_hold = 1;
      end
    end
    os = in_valid && full;
    if (in_valid && !full) begin
      q.push_back('{tag: (m_wr == BS-1), d: 16'(in_data)});
      m_wr = (m_wr + 1) % BS;
    end
    ls = in_done && (m_wr != 0);
    if (ls) m_wr = 0;
    m_ovf = os | (m_ovf & !clear_err);
    m_len = ls | (m_len & !clear_err);
  endtask

  task automatic compare();
    chk("out_valid", out_valid, m_hold);
    chk("fifo_level", fifo_level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("len_err", len_err, m_len);
    if (m_hold) begin
      chk("out_data", out_data, {m_l1, m_l0});
      chk("out_last", out_last, m_last);
    end
  endtask

  task automatic cycle();
    step_model();
    @(posedge clk);
    @(negedge clk);
    compare();
    if (out_valid7) q7.push_back({out_last7, out_data7});
  endtask

  task automatic feed(int v);
    in_valid = 1'b1; in_data = DW'(v);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_blk(string name, logic [32:0] exp [8], int n);
    chk({name, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk(name, log_q[i], exp[i]);
  endtask

  logic [32:0] exp34 [8];
  logic [32:0] exp37 [8];

  initial begin
    exp34 = '{{1'b0, 32'h00C80064}, {1'b0, 32'h0190012C}, {1'b0, 32'h025801F4},
              {1'b1, 32'h032002BC}, 33'h0, 33'h0, 33'h0, 33'h0};
    exp37 = '{{1'b0, 32'h00020001}, {1'b0, 32'h00040003}, {1'b0, 32'h000B0005},
              {1'b0, 32'h000D000C}, {1'b0, 32'h000F000E}, {1'b0, 32'h00110010},
              {1'b1, 32'h00000012}, 33'h0};

    reset_n = 1'b0; in_data = '0; in_valid = 0; in_done = 0;
    out_ready = 1'b1; clear_err = 0; in_valid7 = 0;
    model_reset();
    idle(2);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_last", out_last, 1'b0);
    reset_n = 1'b1;
    idle(2);

    // four-word block at one sample per cycle
    log_q.delete();
    for (int k = 1; k <= 8; k++) feed(100 * k);
    idle(20);
    chk_blk("blk8_word", exp34, 4);

    // stall consumer: 18 samples retained, two dropped
    log_q.delete();
    out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) feed(k);
    idle(2);
    chk("stall_level", fifo_level, 5'd16);
    chk("stall_overflow", overflow, 1'b1);
    chk("stall_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    idle(40);
    chk("stall_count", log_q.size(), 9);
    for (int i = 0; i < 9 && i < log_q.size(); i++)
      chk("stall_word", log_q[i],
          {(i == 3 || i == 7) ? 1'b1 : 1'b0, 16'(2*i+2), 16'(2*i+1)});
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    chk("clear_overflow", overflow, 1'b0);

    // short block then a full one
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    log_q.delete();
    for (int k = 1; k <= 5; k++) feed(k);
    in_done = 1'b1; cycle(); in_done = 1'b0;
    idle(3);
    chk("short_len_err", len_err, 1'b1);
    for (int k = 11; k <= 18; k++) feed(k);
    idle(20);
    chk_blk("short_word", exp37, 7);

    // reset mid-block
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) feed(k);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    compare();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_level", fifo_level, 5'd0);
    chk("midrst_flags", {overflow, len_err}, 2'b00);
    cycle();
    reset_n = 1'b1;
    out_ready = 1'b1;
    log_q.delete();
    for (int k = 1; k <= 8; k++) feed(100 * k);
    idle(20);
    chk_blk("after_rst_word", exp34, 4);

    // seven-sample block on the BLOCK_SIZE=7 instance
    q7.delete();
    for (int k = 1; k <= 7; k++) begin
      in_valid7 = 1'b1; in_data = DW'(100 * k);
      cycle();
    end
    in_valid7 = 1'b0;
    idle(20);
    chk("blk7_count", q7.size(), 4);
    if (q7.size() == 4) begin
      chk("blk7_first", q7[0], {1'b0, 32'h00C80064});
      chk("blk7_final", q7[3], {1'b1, 32'h000002BC});
    end

    // random traffic with varying consumer pressure
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = DW'($urandom);
        in_done   = ($urandom_range(0, 39) == 0);
        clear_err = ($urandom_range(0, 49) == 0);
        out_ready = ($urandom_range(0, 5) < seg);
        cycle();
      end
    end
    in_valid = 0; in_done = 0; clear_err = 0; out_ready = 1'b1;
    idle(60);
    chk("drain_level", fifo_level, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
